// File: rtl/mem_ctrl_if.sv
// Bus bundle between the RAM controller, the byte-wide RAM port and its two
// requesters: the instruction-cache fetch path and the load/store path.
// The controller uses the slave view; the requesters and RAM use the master view.
interface mem_ctrl_if;
    // Byte-wide RAM port
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    // Instruction-cache word fetch
    logic        IC_query_en;
    logic [31:0] IC_query_addr;
    logic        IC_data_en;
    logic [31:0] IC_data;

    // Load/store requests
    logic        LS_query_en;
    logic [31:0] LS_query_addr;
    logic        LS_wr;
    logic [1:0]  LS_size;
    logic [31:0] LS_wdata;
    logic        LS_data_en;
    logic [31:0] LS_data;

    modport slave (
        input  mem_din,
        output mem_dout, mem_a, mem_wr,
        input  IC_query_en, IC_query_addr,
        output IC_data_en, IC_data,
        input  LS_query_en, LS_query_addr, LS_wr, LS_size, LS_wdata,
        output LS_data_en, LS_data
    );

    modport master (
        output mem_din,
        input  mem_dout, mem_a, mem_wr,
        output IC_query_en, IC_query_addr,
        input  IC_data_en, IC_data,
        output LS_query_en, LS_query_addr, LS_wr, LS_size, LS_wdata,
        input  LS_data_en, LS_data
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM controller and round-robin arbiter between the instruction
// cache and the load/store unit. One requester at a time owns the byte-wide
// RAM port; the controller issues 1, 2 or 4 consecutive byte addresses,
// assembles read bytes little-endian, and acknowledges with a one-cycle pulse.
module mem_ctrl (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      flush_signal,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Transaction context, latched on grant
    state_e      state_q;
    owner_e      owner_q;
    owner_e      last_grant_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  len_q;
    logic [2:0]  cnt_q;

    // Read assembly and pause bookkeeping
    logic [31:0] rdata_q;
    logic        restart_q;

    // Registered outputs
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        ic_data_en_q;
    logic [31:0] ic_data_q;
    logic        ls_data_en_q;
    logic [31:0] ls_data_q;

    // Combinational helpers
    logic        grant_any;
    logic        grant_ic;
    logic [2:0]  ls_len;
    logic [2:0]  rd_cnt;
    logic [2:0]  rd_next;
    logic [1:0]  rd_prev;
    logic [31:0] rd_next_addr;
    logic [31:0] rd_word;
    logic [2:0]  wr_next;
    logic [31:0] wr_next_addr;
    logic [7:0]  wr_next_byte;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        grant_any = 1'b0;
        grant_ic  = 1'b0;
        ls_len    = 3'd4;
        grant_any = bus.IC_query_en | bus.LS_query_en;
        grant_ic  = bus.IC_query_en & (~bus.LS_query_en | (last_grant_q == OWN_LS));
        case (bus.LS_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // Read datapath: byte index on the bus this cycle, and the word with the
    // byte returned for the previous address merged in.
    always_comb begin
        rd_cnt       = restart_q ? 3'd0 : cnt_q;
        rd_next      = rd_cnt + 3'd1;
        rd_prev      = rd_cnt[1:0] - 2'd1;
        rd_next_addr = addr_q + {29'd0, rd_next};
        rd_word      = rdata_q;
        if (rd_cnt != 3'd0) begin
            rd_word[{rd_prev, 3'b000} +: 8] = bus.mem_din;
        end
    end

    // Write datapath: address and data for the following byte.
    always_comb begin
        wr_next      = cnt_q + 3'd1;
        wr_next_addr = addr_q + {29'd0, wr_next};
        wr_next_byte = wdata_q[{wr_next[1:0], 3'b000} +: 8];
    end

    // After a pause in READ the first ready cycle re-issues byte 0 directly;
    // all other cycles present the registered address.
    assign bus.mem_a      = (state_q == S_READ && restart_q && rdy_in) ? addr_q : mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.IC_data_en = ic_data_en_q;
    assign bus.IC_data    = ic_data_q;
    assign bus.LS_data_en = ls_data_en_q;
    assign bus.LS_data    = ls_data_q;

    // Main FSM: grant, byte sequencing, completion pulse, flush abort and pause hold.
    // NOTE: asynchronous active-low reset clears every state and output register immediately, without waiting for a clock.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IC;
            last_grant_q <= OWN_LS;
            addr_q       <= '0;
            wdata_q      <= '0;
            len_q        <= 3'd0;
            cnt_q        <= 3'd0;
            rdata_q      <= '0;
            restart_q    <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            ic_data_en_q <= 1'b0;
            ic_data_q    <= '0;
            ls_data_en_q <= 1'b0;
            ls_data_q    <= '0;
        end else if (flush_signal && state_q == S_READ) begin
            // Misprediction: drop the read and its partial data.
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            restart_q <= 1'b0;
            rdata_q   <= '0;
            mem_a_q   <= '0;
        end else if (!rdy_in) begin
            // Everything holds; an interrupted read is re-issued from byte 0.
            if (state_q == S_READ) begin
                restart_q <= 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any && !flush_signal) begin
                        cnt_q     <= 3'd0;
                        restart_q <= 1'b0;
                        rdata_q   <= '0;
                        if (grant_ic) begin
                            owner_q      <= OWN_IC;
                            last_grant_q <= OWN_IC;
                            addr_q       <= bus.IC_query_addr;
                            len_q        <= 3'd4;
                            mem_a_q      <= bus.IC_query_addr;
                            state_q      <= S_READ;
                        end else begin
                            owner_q      <= OWN_LS;
                            last_grant_q <= OWN_LS;
                            addr_q       <= bus.LS_query_addr;
                            wdata_q      <= bus.LS_wdata;
                            len_q        <= ls_len;
                            mem_a_q      <= bus.LS_query_addr;
                            if (bus.LS_wr) begin
                                mem_wr_q   <= 1'b1;
                                mem_dout_q <= bus.LS_wdata[7:0];
                                state_q    <= S_WRITE;
                            end else begin
                                state_q    <= S_READ;
                            end
                        end
                    end
                end

                S_READ: begin
                    restart_q <= 1'b0;
                    if (rd_cnt == len_q) begin
                        // Last byte arrives this cycle: complete.
                        cnt_q   <= 3'd0;
                        mem_a_q <= '0;
                        rdata_q <= rd_word;
                        state_q <= S_DONE;
                        if (owner_q == OWN_IC) begin
                            ic_data_en_q <= 1'b1;
                            ic_data_q    <= rd_word;
                        end else begin
                            ls_data_en_q <= 1'b1;
                            ls_data_q    <= rd_word;
                        end
                    end else begin
                        cnt_q   <= rd_next;
                        rdata_q <= rd_word;
                        mem_a_q <= (rd_next == len_q) ? 32'd0 : rd_next_addr;
                    end
                end

                S_WRITE: begin
                    if (cnt_q == len_q - 3'd1) begin
                        cnt_q        <= 3'd0;
                        mem_wr_q     <= 1'b0;
                        mem_a_q      <= '0;
                        mem_dout_q   <= '0;
                        ls_data_en_q <= 1'b1;
                        ls_data_q    <= '0;
                        state_q      <= S_DONE;
                    end else begin
                        cnt_q      <= wr_next;
                        mem_a_q    <= wr_next_addr;
                        mem_dout_q <= wr_next_byte;
                    end
                end

                S_DONE: begin
                    ic_data_en_q <= 1'b0;
                    ic_data_q    <= '0;
                    ls_data_en_q <= 1'b0;
                    ls_data_q    <= '0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// traffic, checked against a transaction-level model of latency, arbitration
// order and RAM contents.
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_signal;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_signal (flush_signal),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    // Byte-addressed RAM; unwritten locations hold an address-derived pattern.
    logic [7:0]  ram [logic [31:0]];
    logic [31:0] ram_a;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[23:16] ^ 8'h5A;
    endfunction

    // RAM: writes on the clock edge, read data valid the cycle after the address.
    always @(posedge clk_in) begin
        ram_a = bus.mem_a;
        if (bus.mem_wr === 1'b1) ram[bus.mem_a] = bus.mem_dout;
        #1;
        bus.mem_din = ram_rd(ram_a);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit last_ls;                 // model of the last granted requester
    logic [31:0] last_data;
    logic [31:0] a_log [64];
    logic [7:0]  d_log [64];
    logic        w_log [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int op_len(input bit own_ls, input logic [1:0] size);
        if (!own_ls || size[1]) return 4;
        return (size == 2'd1) ? 2 : 1;
    endfunction

    // One request from a single requester. ps/pl: rdy_in low for pl cycles from
    // cycle offset ps (ps<0: none). fl: cycle offset of a one-cycle flush (<0: none).
    task automatic run_op(input bit own_ls, input logic [31:0] addr, input bit wr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input int ps, input int pl, input int fl, input string tag);
        int n, exp_lat, got, other, wr_cycles;
        bit is_wr;
        logic [31:0] exp_data, got_data;
        logic [7:0] beyond;
        n = op_len(own_ls, size);
        is_wr = own_ls && wr;
        exp_data = '0;
        if (!is_wr) for (int k = 0; k < n; k++) exp_data[8*k +: 8] = ram_rd(addr + k);
        beyond = ram_rd(addr + n);
        exp_lat = is_wr ? n + 1 : n + 2;
        if (ps > 0) exp_lat += pl + (is_wr ? 0 : ps - 1);
        if (fl == 0) exp_lat += 1;
        got = -1; other = 0; wr_cycles = 0; got_data = 'x;
        if (own_ls) begin
            bus.LS_query_en = 1'b1; bus.LS_query_addr = addr;
            bus.LS_wr = wr; bus.LS_size = size; bus.LS_wdata = wdata;
        end else begin
            bus.IC_query_en = 1'b1; bus.IC_query_addr = addr;
        end
        for (int c = 0; c < 48; c++) begin
            rdy_in = !(ps > 0 && c >= ps && c < ps + pl);
            flush_signal = (c == fl);
            #1;
            a_log[c] = bus.mem_a; d_log[c] = bus.mem_dout; w_log[c] = bus.mem_wr;
            if (bus.mem_wr) wr_cycles++;
            if (own_ls ? bus.IC_data_en : bus.LS_data_en) other++;
            if (own_ls ? bus.LS_data_en : bus.IC_data_en) begin
                got = c;
                got_data = own_ls ? bus.LS_data : bus.IC_data;
                break;
            end
            next_cycle();
        end
        next_cycle();
        bus.IC_query_en = 1'b0; bus.LS_query_en = 1'b0;
        rdy_in = 1'b1; flush_signal = 1'b0;
        last_ls = own_ls;
        last_data = got_data;
        check({tag, " latency"}, got, exp_lat);
        check({tag, " data"}, got_data, exp_data);
        check({tag, " other data_en"}, other, 0);
        if (!is_wr) begin
            check({tag, " no write"}, wr_cycles, 0);
        end else begin
            for (int k = 0; k < n; k++) check({tag, " ram byte"}, ram_rd(addr + k), wdata[8*k +: 8]);
            check({tag, " ram beyond"}, ram_rd(addr + n), beyond);
        end
    endtask

    // IC fetch and LS request raised together; order follows round-robin.
    task automatic run_both(input logic [31:0] ic_addr, input logic [31:0] ls_addr, input bit ls_wr,
                            input logic [1:0] ls_size, input logic [31:0] ls_wdata, input string tag);
        int n_ls, lat_ic, lat_ls, exp_first, exp_ic, exp_ls, ic_c, ls_c;
        bit first_ls;
        logic [31:0] exp_ic_d, exp_ls_d, ic_d, ls_d;
        first_ls = !last_ls;
        n_ls = op_len(1'b1, ls_size);
        lat_ic = 6;
        lat_ls = ls_wr ? n_ls + 1 : n_ls + 2;
        exp_ic_d = '0; exp_ls_d = '0;
        for (int k = 0; k < 4; k++) exp_ic_d[8*k +: 8] = ram_rd(ic_addr + k);
        if (!ls_wr) for (int k = 0; k < n_ls; k++) exp_ls_d[8*k +: 8] = ram_rd(ls_addr + k);
        exp_first = first_ls ? lat_ls : lat_ic;
        exp_ic = first_ls ? exp_first + 1 + lat_ic : exp_first;
        exp_ls = first_ls ? exp_first : exp_first + 1 + lat_ls;
        ic_c = -1; ls_c = -1; ic_d = 'x; ls_d = 'x;
        bus.IC_query_en = 1'b1; bus.IC_query_addr = ic_addr;
        bus.LS_query_en = 1'b1; bus.LS_query_addr = ls_addr;
        bus.LS_wr = ls_wr; bus.LS_size = ls_size; bus.LS_wdata = ls_wdata;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (bus.IC_data_en) begin ic_c = c; ic_d = bus.IC_data; end
            if (bus.LS_data_en) begin ls_c = c; ls_d = bus.LS_data; end
            if (ic_c >= 0 && ls_c >= 0) break;
            next_cycle();
            if (ic_c >= 0) bus.IC_query_en = 1'b0;
            if (ls_c >= 0) bus.LS_query_en = 1'b0;
        end
        next_cycle();
        bus.IC_query_en = 1'b0; bus.LS_query_en = 1'b0;
        last_ls = !first_ls;
        check({tag, " ic cycle"}, ic_c, exp_ic);
        check({tag, " ls cycle"}, ls_c, exp_ls);
        check({tag, " ic data"}, ic_d, exp_ic_d);
        check({tag, " ls data"}, ls_d, exp_ls_d);
        if (ls_wr) for (int k = 0; k < n_ls; k++) check({tag, " ls ram"}, ram_rd(ls_addr + k), ls_wdata[8*k +: 8]);
    endtask

    initial begin
        int ic_seen;
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
        bus.mem_din = '0;
        bus.IC_query_en = 1'b0; bus.IC_query_addr = '0;
        bus.LS_query_en = 1'b0; bus.LS_query_addr = '0;
        bus.LS_wr = 1'b0; bus.LS_size = '0; bus.LS_wdata = '0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h50; ram[32'h103] = 8'h00;
        ram[32'h2002] = 8'hFF; ram[32'h2003] = 8'h80;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset mem_a", bus.mem_a, 0);
        check("reset mem_wr", bus.mem_wr, 0);
        check("reset mem_dout", bus.mem_dout, 0);
        check("reset IC_data_en", bus.IC_data_en, 0);
        check("reset LS_data_en", bus.LS_data_en, 0);
        check("reset IC_data", bus.IC_data, 0);
        check("reset LS_data", bus.LS_data, 0);
        rst_in = 1'b1;
        last_ls = 1'b1;
        next_cycle();

        // Word fetch with known bytes
        run_op(1'b0, 32'h100, 1'b0, 2'd2, 0, -1, 0, -1, "ic fetch");
        check("ic fetch word", last_data, 32'h00500513);
        for (int k = 0; k < 4; k++) check("ic fetch addr", a_log[1 + k], 32'h100 + k);

        // Byte store: exactly one write beat
        run_op(1'b1, 32'h1004, 1'b1, 2'd0, 32'h123456AB, -1, 0, -1, "byte store");
        check("byte store wr", w_log[1], 1);
        check("byte store addr", a_log[1], 32'h1004);
        check("byte store dout", d_log[1], 8'hAB);
        check("byte store wr done", w_log[2], 0);

        // Half load and address wrap-around
        run_op(1'b1, 32'h2002, 1'b0, 2'd1, 0, -1, 0, -1, "half load");
        check("half load word", last_data, 32'h000080FF);
        run_op(1'b1, 32'hFFFFFFFE, 1'b0, 2'd3, 0, -1, 0, -1, "wrap load");
        check("wrap addr0", a_log[1], 32'hFFFFFFFE);
        check("wrap addr1", a_log[2], 32'hFFFFFFFF);
        check("wrap addr2", a_log[3], 32'h00000000);
        check("wrap addr3", a_log[4], 32'h00000001);

        // Flush during IC read at byte 2
        ic_seen = 0;
        bus.IC_query_en = 1'b1; bus.IC_query_addr = 32'h300;
        for (int c = 0; c < 14; c++) begin
            flush_signal = (c == 3);
            if (c == 4) bus.IC_query_en = 1'b0;
            #1;
            if (c == 3) check("flush read byte2 addr", bus.mem_a, 32'h302);
            if (c == 4) check("flush read addr cleared", bus.mem_a, 0);
            if (bus.IC_data_en) ic_seen++;
            next_cycle();
        end
        flush_signal = 1'b0;
        last_ls = 1'b0;
        check("flush read no data_en", ic_seen, 0);
        run_op(1'b0, 32'h104, 1'b0, 2'd2, 0, -1, 0, -1, "fetch after flush");

        // Flush during a store is ignored
        run_op(1'b1, 32'h40, 1'b1, 2'd2, 32'hDEADBEEF, -1, 0, 2, "flush store");
        check("flush store byte0", ram_rd(32'h40), 8'hEF);
        check("flush store byte3", ram_rd(32'h43), 8'hDE);

        // Flush in IDLE delays the grant by one cycle
        run_op(1'b1, 32'h2100, 1'b0, 2'd2, 0, -1, 0, 0, "flush idle");

        // Pause mid word read: restart from byte 0
        run_op(1'b1, 32'h2400, 1'b0, 2'd2, 0, 3, 3, -1, "paused load");

        // Reset in the middle of a store
        bus.LS_query_en = 1'b1; bus.LS_query_addr = 32'h500;
        bus.LS_wr = 1'b1; bus.LS_size = 2'd2; bus.LS_wdata = $urandom;
        next_cycle();
        next_cycle();
        #1;
        check("store active before reset", bus.mem_wr, 1);
        #1;
        rst_in = 1'b0;
        #1;
        check("reset mid-store mem_wr", bus.mem_wr, 0);
        check("reset mid-store mem_a", bus.mem_a, 0);
        check("reset mid-store mem_dout", bus.mem_dout, 0);
        check("reset mid-store LS_data_en", bus.LS_data_en, 0);
        bus.LS_query_en = 1'b0;
        next_cycle();
        rst_in = 1'b1;
        last_ls = 1'b1;

        // Arbitration after reset: IC first, then alternating
        run_both(32'h600, 32'h8000_0600, 1'b0, 2'd2, 0, "tie after reset");
        run_both(32'h700, 32'h8000_0700, 1'b0, 2'd0, 0, "tie again");
        run_op(1'b0, 32'h800, 1'b0, 2'd2, 0, -1, 0, -1, "ic alone");
        run_both(32'h900, 32'h8000_0900, 1'b1, 2'd1, 32'h0000C0DE, "tie after ic");

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            int kind, n, ps, pl, fl;
            bit wr;
            logic [1:0] size;
            logic [31:0] ic_a, ls_a, wd;
            kind = $urandom_range(0, 3);
            wr = $urandom_range(0, 1);
            size = 2'($urandom_range(0, 3));
            ic_a = {16'h0000, 16'($urandom)};
            ls_a = {16'h8000, 16'($urandom_range(0, 255))};
            wd = $urandom;
            ps = -1; pl = 0; fl = -1;
            if (kind == 3) begin
                run_both(ic_a, ls_a, wr, size, wd, "rand tie");
            end else begin
                n = op_len(kind != 0, size);
                if ($urandom_range(0, 1) == 1) begin
                    ps = $urandom_range(1, (kind != 0 && wr) ? n : n + 1);
                    pl = $urandom_range(1, 4);
                end else if ($urandom_range(0, 3) == 0) begin
                    fl = 0;
                end
                if (kind != 0 && wr && ps < 0 && $urandom_range(0, 1) == 1) fl = $urandom_range(1, n);
                run_op(kind != 0, (kind == 0) ? ic_a : ls_a, wr, size, wd, ps, pl, fl, "rand op");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
